// File: rtl/aes_192_decrypt_iter.sv
// Iterative AES-192 inverse cipher: key schedule expanded in place over 8 cycles,
// then one inverse round per cycle. Plaintext appears on out with a one-cycle
// out_valid pulse; key material and state can be wiped right after completion.
//
// state  | meaning
// IDLE   | waiting for a rising edge on start
// KEYEXP | producing six schedule words per cycle (8 cycles)
// ADDKEY | initial whitening with the last round key
// ROUND  | inverse rounds 11..0, round 0 drives out
// DONE   | out_valid pulse cycle
// ZERO   | wipes round keys, state and ciphertext before idling
module aes_192_decrypt_iter #(
   parameter bit ZEROIZE_ON_DONE = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] state,
   input  logic [191:0] key,
   output logic [127:0] out,
   output logic         out_valid,
   output logic         busy
);

   typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, DONE, ZERO} fsm_t;

   fsm_t         fsm;
   logic         start_r;
   logic [2:0]   kcnt;
   logic [3:0]   r;
   logic [127:0] ct;
   logic [127:0] s;
   // Schedule words; the newest six always live in wk[48..53] and older words
   // shift down, so after expansion wk[n] holds w[n] for every n.
   logic [31:0]  wk [0:53];
   logic [31:0]  nw [0:5];
   logic [127:0] rk_cur;
   logic [127:0] rk_last;
   logic [127:0] round_out;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse (and maps 0 to 0).
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] t;
      logic [7:0] acc;
      t   = a;
      acc = 8'h01;
      for (int k = 1; k < 8; k++) begin
         t   = gmul(t, t);
         acc = gmul(acc, t);
      end
      return acc;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] b;
      b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return ginv(b);
   endfunction

   // InvShiftRows, InvSubBytes, AddRoundKey and (unless last) InvMixColumns.
   function automatic logic [127:0] inv_round(input logic [127:0] v, input logic [127:0] k,
                                              input logic last);
      logic [127:0] t;
      logic [127:0] m;
      logic [7:0]   a0, a1, a2, a3;
      int           src;
      t = '0;
      m = '0;
      for (int b = 0; b < 16; b++) begin
         src = (b % 4) + 4 * (((b / 4) - (b % 4) + 4) % 4);
         t[127-8*b -: 8] = inv_sbox(v[127-8*src -: 8]);
      end
      t = t ^ k;
      if (last) return t;
      for (int c = 0; c < 4; c++) begin
         a0 = t[127-32*c -: 8];
         a1 = t[119-32*c -: 8];
         a2 = t[111-32*c -: 8];
         a3 = t[103-32*c -: 8];
         m[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         m[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         m[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         m[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return m;
   endfunction

   // Next six schedule words from the current window, plus round-key selection.
   always_comb begin
      logic [31:0] rw;
      logic [7:0]  rcon;
      rw    = {wk[53][23:0], wk[53][31:24]};
      rcon  = 8'h01 << kcnt;
      nw[0] = wk[48] ^ {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])}
                     ^ {rcon, 24'h000000};
      for (int j = 1; j < 6; j++) nw[j] = wk[48+j] ^ nw[j-1];
      rk_cur    = {wk[{r, 2'b00}], wk[{r, 2'b01}], wk[{r, 2'b10}], wk[{r, 2'b11}]};
      rk_last   = {wk[48], wk[49], wk[50], wk[51]};
      round_out = inv_round(s, rk_cur, (r == 4'd0));
   end

   // Sequencer and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         start_r   <= 1'b0;
         fsm       <= IDLE;
         out       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         kcnt      <= '0;
         r         <= '0;
         ct        <= '0;
         s         <= '0;
         for (int i = 0; i < 54; i++) wk[i] <= '0;
      end else begin
         start_r <= start;
         case (fsm)
            IDLE: begin
               if (start && !start_r) begin
                  for (int i = 0; i < 6; i++) wk[48+i] <= key[191-32*i -: 32];
                  ct   <= state;
                  kcnt <= '0;
                  busy <= 1'b1;
                  fsm  <= KEYEXP;
               end
            end
            KEYEXP: begin
               for (int i = 0; i < 48; i++) wk[i] <= wk[i+6];
               for (int j = 0; j < 6; j++) wk[48+j] <= nw[j];
               kcnt <= kcnt + 3'd1;
               if (kcnt == 3'd7) fsm <= ADDKEY;
            end
            ADDKEY: begin
               s   <= ct ^ rk_last;
               r   <= 4'd11;
               fsm <= ROUND;
            end
            ROUND: begin
               if (r == 4'd0) begin
                  out       <= round_out;
                  out_valid <= 1'b1;
                  fsm       <= DONE;
               end else begin
                  s <= round_out;
                  r <= r - 4'd1;
               end
            end
            DONE: begin
               out_valid <= 1'b0;
               if (ZEROIZE_ON_DONE) begin
                  ct  <= '0;
                  s   <= '0;
                  for (int i = 0; i < 54; i++) wk[i] <= '0;
                  fsm <= ZERO;
               end else begin
                  busy <= 1'b0;
                  fsm  <= IDLE;
               end
            end
            ZERO: begin
               ct   <= '0;
               s    <= '0;
               for (int i = 0; i < 54; i++) wk[i] <= '0;
               busy <= 1'b0;
               fsm  <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule
